viterbi_core_arbiter: RTL

//  Shares one viterbi decoder core between NREQ requesters. Each requester posts a LENIN-bit code word.
//  The block grants round-robin, pulses the core's reset, and waits for the core's finish flag.
//  It then returns the LENOUT-bit decoded word, tagged with the requester id.
//  It sits between the requesters and the viterbi core instance; it owns the core's rst and codein.

---
 rtl/viterbi_core_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/viterbi_core_arbiter.sv
// Round-robin arbiter that shares one viterbi core between NREQ requesters; one job in flight, response held until rsp_ready.
// Optional RUN-state watchdog under VITERBI_ARB_TIMEOUT_EN (aborted jobs return rsp_err=1, rsp_data=0).
module viterbi_core_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int LENIN   = 10,
  parameter int LENOUT  = 5,
  parameter int CLR_CYC = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*LENIN-1:0]   req_code,
  output logic                    core_rst,
  output logic [LENIN-1:0]        core_codein,
  input  logic [LENOUT-1:0]       core_codeout,
  input  logic                    core_finish,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [LENOUT-1:0]       rsp_data,
  output logic                    rsp_err,
  output logic                    busy
);

  localparam int CCW = (CLR_CYC < 2) ? 1 : $clog2(CLR_CYC);
  localparam int RCW = (TIMEOUT < 2) ? 2 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_CLR, S_RUN, S_RESP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDW-1:0]    rr_ptr;
  logic [CCW-1:0]    clr_cnt;
  logic [RCW-1:0]    run_cnt;

  logic              gnt_any;
  logic [NREQ-1:0]   gnt_oh;
  logic [IDW-1:0]    gnt_idx;
  logic [IDW-1:0]    rr_nxt;
  logic [LENIN-1:0]  gnt_code;
  logic              clr_done;
  logic              fin_ok;
  logic              to_ok;

  // Scan from rr_ptr upward (wrapping) for the first pending requester.
  always_comb begin
    int p;
    logic [NREQ-1:0] sel;
    gnt_any = 1'b0;
    gnt_oh  = '0;
    gnt_idx = '0;
    p       = 0;
    sel     = '0;
    for (int k = 0; k < NREQ; k++) begin
      p   = (int'(rr_ptr) + k) % NREQ;
      sel = NREQ'(1) << p;
      if (!gnt_any && ((req_valid & sel) != '0)) begin
        gnt_any = 1'b1;
        gnt_oh  = sel;
        gnt_idx = IDW'(p);
      end
    end
  end

  always_comb begin
    gnt_code = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_oh[i]) gnt_code = req_code[i*LENIN +: LENIN];
    end
  end

  assign rr_nxt    = IDW'((int'(gnt_idx) + 1) % NREQ);
  assign req_ready = (state == S_IDLE) ? gnt_oh : '0;
  assign busy      = (state != S_IDLE);
  assign clr_done  = (clr_cnt == CCW'(CLR_CYC - 1));
  // The first RUN cycle may still see the previous job's finish flag.
  assign fin_ok    = core_finish && (run_cnt != '0);

`ifdef VITERBI_ARB_TIMEOUT_EN
  assign to_ok = (run_cnt == RCW'(TIMEOUT - 1));
`else
  assign to_ok = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (gnt_any)          state_nxt = S_CLR;
      S_CLR:  if (clr_done)         state_nxt = S_RUN;
      S_RUN:  if (fin_ok || to_ok)  state_nxt = S_RESP;
      S_RESP: if (rsp_ready)        state_nxt = S_IDLE;
      default:                      state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      clr_cnt     <= '0;
      run_cnt     <= '0;
      core_rst    <= 1'b0;
      core_codein <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_data    <= '0;
    end else begin
      state     <= state_nxt;
      core_rst  <= (state_nxt == S_RUN);
      rsp_valid <= (state_nxt == S_RESP);
      case (state)
        S_IDLE: begin
          if (gnt_any) begin
            core_codein <= gnt_code;
            rsp_id      <= gnt_idx;
            rr_ptr      <= rr_nxt;
            clr_cnt     <= '0;
          end
        end
        S_CLR: begin
          clr_cnt <= clr_cnt + CCW'(1);
          run_cnt <= '0;
        end
        S_RUN: begin
          if (run_cnt != '1) run_cnt <= run_cnt + RCW'(1);
          if (fin_ok)     rsp_data <= core_codeout;
          else if (to_ok) rsp_data <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef VITERBI_ARB_TIMEOUT_EN
  logic err_q;
  // Finish takes priority over a coincident timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (state == S_RUN && (fin_ok || to_ok)) begin
      err_q <= !fin_ok;
    end
  end
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule
